// File: rtl/pwm_dbuf_pkg.sv
// Shared definitions for the double-buffered PWM core: slot register
// addresses, CTRL bit positions and the duty-register address helper.
package pwm_dbuf_pkg;

    typedef logic [31:0] word_t;

    localparam logic [4:0] ADDR_DVSR      = 5'd0;
    localparam logic [4:0] ADDR_CTRL      = 5'd1;
    localparam logic [4:0] ADDR_PCNT      = 5'd2;
    localparam logic [4:0] ADDR_POL       = 5'd3;
    localparam logic [4:0] ADDR_DUTY_BASE = 5'h10;

    localparam int unsigned EN_BIT = 0;

    // Word address of the duty shadow register for channel idx.
    function automatic logic [4:0] duty_addr(input int unsigned idx);
        return ADDR_DUTY_BASE + 5'(idx);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler and R-bit period counter shared by all PWM channels.
// tick marks the prescaler terminal count; boundary marks the last tick
// of a PWM period. Both counters are held at zero while en is low.
module pwm_timebase #(
    parameter int unsigned R = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [31:0]  dvsr,
    output logic [R-1:0] d,
    output logic         tick,
    output logic         boundary
);

    logic [31:0] q;

    // Equality only: a DVSR below the running q lets q wrap through 2^32.
    assign tick     = en && (q == dvsr);
    assign boundary = tick && (d == '1);

    // Prescaler and period counter advance; cleared on reset or disable.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            q <= '0;
            d <= '0;
        end else begin
            q <= tick ? '0 : q + 32'd1;
            if (tick) begin
                d <= d + R'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_dbuf_core.sv
// Multi-channel PWM slot with double-buffered duty registers.
// Duty writes land in a shadow register and are copied to the active
// compare value only at a period boundary (or continuously while disabled).
// Optional feature macro: PWM_POLARITY_EN adds a per-channel output
// polarity register at address 3 that also sets the idle level.
module pwm_dbuf_core
    import pwm_dbuf_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned R = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    output logic [W-1:0] pwm
);

    logic         wr_en;
    logic [31:0]  dvsr;
    logic         en;
    logic [31:0]  pcnt;
    logic [R:0]   shadow [W];
    logic [R:0]   active [W];
    logic [W-1:0] pol;
    logic [R-1:0] d;
    logic         tick;
    logic         boundary;

    // Reads are a pure address mux, so the read strobe carries no state.
    logic unused_read;
    assign unused_read = read;

    assign wr_en = cs && write;

    pwm_timebase #(
        .R(R)
    ) u_timebase (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .dvsr     (dvsr),
        .d        (d),
        .tick     (tick),
        .boundary (boundary)
    );

    // Slot register file: prescaler, control, period count, duty shadows.
    always_ff @(posedge clk) begin
        if (reset) begin
            dvsr <= '0;
            en   <= 1'b0;
            pcnt <= '0;
            for (int unsigned i = 0; i < W; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            if (wr_en && addr == ADDR_DVSR) begin
                dvsr <= wr_data;
            end
            if (wr_en && addr == ADDR_CTRL) begin
                en <= wr_data[EN_BIT];
            end
            if (wr_en && addr == ADDR_PCNT) begin
                pcnt <= '0;
            end else if (boundary) begin
                pcnt <= pcnt + 32'd1;
            end
            for (int unsigned i = 0; i < W; i++) begin
                if (wr_en && addr == duty_addr(i)) begin
                    shadow[i] <= wr_data[R:0];
                end
            end
        end
    end

`ifdef PWM_POLARITY_EN
    // Output polarity; takes effect on the next edge, not double-buffered.
    always_ff @(posedge clk) begin
        if (reset) begin
            pol <= '0;
        end else if (wr_en && addr == ADDR_POL) begin
            pol <= wr_data[W-1:0];
        end
    end
`else
    assign pol = '0;
`endif

    // Active duty follows the shadow while idle, otherwise only at boundaries.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < W; i++) begin
                active[i] <= '0;
            end
        end else if (!en || boundary) begin
            for (int unsigned i = 0; i < W; i++) begin
                active[i] <= shadow[i];
            end
        end
    end

    // Registered compare; the R+1-bit duty makes 2^R a constant-high level.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm <= '0;
        end else begin
            for (int unsigned i = 0; i < W; i++) begin
                pwm[i] <= en ? (({1'b0, d} < active[i]) ^ pol[i]) : pol[i];
            end
        end
    end

    // Combinational read mux; unmapped addresses read zero.
    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_DVSR: rd_data = dvsr;
            ADDR_CTRL: rd_data[EN_BIT] = en;
            ADDR_PCNT: rd_data = pcnt;
`ifdef PWM_POLARITY_EN
            ADDR_POL:  rd_data[W-1:0] = pol;
`endif
            default: begin
                for (int unsigned i = 0; i < W; i++) begin
                    if (addr == duty_addr(i)) begin
                        rd_data[R:0] = shadow[i];
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_dbuf_core.sv
// Self-checking bench for pwm_dbuf_core. Expected waveforms come from the
// period arithmetic: sample j after enable sits at counter value
// (j mod L)/(DVSR+1) with L = (DVSR+1)*2^R, and a duty write applies to
// the first period whose preceding boundary edge is strictly later than
// the edge that commits the write.
module tb_pwm_dbuf_core;
    import pwm_dbuf_pkg::*;

    localparam int W   = 8;
    localparam int R   = 10;
    localparam int PER = 1 << R;

    logic         clk = 1'b0;
    logic         reset;
    logic         cs;
    logic         read;
    logic         write;
    logic [4:0]   addr;
    logic [31:0]  wr_data;
    logic [31:0]  rd_data;
    logic [W-1:0] pwm;

    int n_tests = 0;
    int n_fail  = 0;

    logic [R:0]   duty_m [W];
    logic [W-1:0] pol_m;

    always #5 clk = ~clk;

    pwm_dbuf_core #(
        .W(W),
        .R(R)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .pwm     (pwm)
    );

    task automatic wr(input logic [4:0] a, input logic [31:0] v);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; read = 1'b0; addr = a; wr_data = v;
        @(posedge clk);
        #1;
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        @(negedge clk);
        cs = 1'b1; read = 1'b1; write = 1'b0; addr = a;
        #1;
        v = rd_data;
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic program_and_enable(input int dv);
        wr(ADDR_CTRL, 32'd0);
        wr(ADDR_DVSR, 32'(dv));
        for (int c = 0; c < W; c++) wr(ADDR_DUTY_BASE + 5'(c), 32'(duty_m[c]));
`ifdef PWM_POLARITY_EN
        wr(ADDR_POL, 32'(pol_m));
`endif
        wr(ADDR_PCNT, 32'd0);
        wr(ADDR_CTRL, 32'd1);
    endtask

    // Runs nper full periods from enable; optional duty write after sample wr_j.
    task automatic run_check(input string name, input int dv, input int nper,
                             input int wr_j, input int wr_ch, input logic [R:0] wr_val);
        int L;
        int m;
        int kk;
        int dcount;
        logic [R:0] dm;
        logic e;
        logic [W-1:0] bad;
        int hi_got [W];
        int hi_exp [W];
        logic [31:0] v;
        L = (dv + 1) * PER;
        program_and_enable(dv);
        bad = '0;
        for (int c = 0; c < W; c++) begin hi_got[c] = 0; hi_exp[c] = 0; end
        for (int j = 0; j < nper * L; j++) begin
            @(posedge clk);
            #1;
            m = j / L;
            kk = j % L;
            dcount = kk / (dv + 1);
            for (int c = 0; c < W; c++) begin
                dm = duty_m[c];
                if (c == wr_ch && wr_j >= 0 && m * L > wr_j + 2) dm = wr_val;
                e = (dcount < int'(dm)) ^ pol_m[c];
                if (e) hi_exp[c]++;
                if (pwm[c] === 1'b1) hi_got[c]++;
                if (pwm[c] !== e) bad[c] = 1'b1;
            end
            if (j == wr_j) begin
                cs = 1'b1; write = 1'b1; addr = ADDR_DUTY_BASE + 5'(wr_ch); wr_data = 32'(wr_val);
            end else if (j == wr_j + 1) begin
                cs = 1'b0; write = 1'b0;
            end
            if (kk == L - 1) begin
                for (int c = 0; c < W; c++) begin
                    n_tests++;
                    if (bad[c]) begin
                        n_fail++;
                        $display("FAIL %s period %0d ch %0d: high cycles got %0d want %0d (waveform shape differs)",
                                 name, m, c, hi_got[c], hi_exp[c]);
                    end
                    bad[c] = 1'b0; hi_got[c] = 0; hi_exp[c] = 0;
                end
            end
        end
        rd(ADDR_PCNT, v);
        n_tests++;
        if (v !== 32'(nper)) begin
            n_fail++;
            $display("FAIL %s pcnt: got %0d want %0d", name, v, nper);
        end
        if (wr_j >= 0) duty_m[wr_ch] = wr_val;
        wr(ADDR_CTRL, 32'd0);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [4:0] ra [4];
        logic [W-1:0] seen;
        ra[0] = ADDR_DVSR; ra[1] = ADDR_CTRL; ra[2] = ADDR_PCNT; ra[3] = ADDR_DUTY_BASE;
        for (int c = 0; c < W; c++) duty_m[c] = R'($urandom_range(1, PER - 1));
        program_and_enable(0);
        repeat (40) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        for (int c = 0; c < W; c++) duty_m[c] = '0;
        pol_m = '0;
        for (int i = 0; i < 4; i++) begin
            rd(ra[i], v);
            n_tests++;
            if (v !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_read addr %0h: got %0h want 0", ra[i], v);
            end
        end
        seen = '0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            seen = seen | (pwm ^ pwm) | ((pwm === '0) ? '0 : '1);
        end
        n_tests++;
        if (seen !== '0) begin
            n_fail++;
            $display("FAIL reset_pwm: got nonzero/unknown pwm, want 0 for 20 cycles");
        end
    endtask

    task automatic test_regs();
        logic [31:0] v;
        logic [31:0] r;
        r = $urandom;
        wr(ADDR_DVSR, r); rd(ADDR_DVSR, v);
        n_tests++;
        if (v !== r) begin n_fail++; $display("FAIL dvsr_rb: got %0h want %0h", v, r); end
        wr(ADDR_DVSR, 32'd0);
        wr(ADDR_CTRL, 32'hFFFF_FFFF); rd(ADDR_CTRL, v);
        n_tests++;
        if (v !== 32'd1) begin n_fail++; $display("FAIL ctrl_rb: got %0h want 1", v); end
        wr(ADDR_CTRL, 32'd0);
        wr(ADDR_DUTY_BASE + 5'd3, 32'hFFFF_FFFF); rd(ADDR_DUTY_BASE + 5'd3, v);
        n_tests++;
        if (v !== 32'h7FF) begin n_fail++; $display("FAIL duty_rb: got %0h want 7ff", v); end
        duty_m[3] = 11'h7FF;
        wr(5'h18, 32'hDEAD_BEEF); rd(5'h18, v);
        n_tests++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL unmapped_rb: got %0h want 0", v); end
        wr(ADDR_POL, 32'hFF); rd(ADDR_POL, v);
        n_tests++;
`ifdef PWM_POLARITY_EN
        if (v !== 32'hFF) begin n_fail++; $display("FAIL pol_rb: got %0h want ff", v); end
        wr(ADDR_POL, 32'd0);
`else
        if (v !== 32'd0) begin n_fail++; $display("FAIL pol_rb: got %0h want 0", v); end
`endif
    endtask

    task automatic test_basic();
        for (int c = 0; c < W; c++) duty_m[c] = '0;
        duty_m[0] = 11'd512;
        run_check("half_duty", 0, 3, -1, 0, '0);
    endtask

    task automatic test_extremes();
        duty_m[1] = 11'd0;
        duty_m[2] = 11'd1024;
        run_check("extremes", 1, 2, -1, 0, '0);
    endtask

    task automatic test_mid_write();
        duty_m[0] = 11'd100;
        run_check("mid_write", 0, 3, 300, 0, 11'd700);
        duty_m[0] = 11'd100;
        run_check("boundary_write", 0, 3, PER - 2, 0, 11'd700);
    endtask

    task automatic test_disable();
        logic [W-1:0] exp_v;
        logic [W-1:0] bad;
        logic [31:0] v;
        for (int c = 0; c < W; c++) duty_m[c] = R'($urandom_range(301, PER - 1));
        duty_m[0] = 11'd400;
        program_and_enable(0);
        bad = '0;
        for (int j = 0; j <= 300; j++) begin
            @(posedge clk); #1;
            for (int c = 0; c < W; c++) exp_v[c] = (j < int'(duty_m[c])) ^ pol_m[c];
            bad = bad | (pwm ^ exp_v) | ((pwm === exp_v) ? '0 : '1);
            if (j == 299) begin
                cs = 1'b1; write = 1'b1; addr = ADDR_CTRL; wr_data = 32'd0;
            end else if (j == 300) begin
                cs = 1'b0; write = 1'b0;
            end
        end
        n_tests++;
        if (bad !== '0) begin n_fail++; $display("FAIL pre_disable: bad channels %0h want 0", bad); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (pwm !== pol_m) begin
                n_fail++;
                $display("FAIL disabled_pwm cycle %0d: got %0h want %0h", i, pwm, pol_m);
            end
        end
        rd(ADDR_PCNT, v);
        n_tests++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL disabled_pcnt: got %0d want 0", v); end
        run_check("reenable", 0, 1, -1, 0, '0);
        wr(ADDR_PCNT, 32'd5); rd(ADDR_PCNT, v);
        n_tests++;
        if (v !== 32'd0) begin n_fail++; $display("FAIL pcnt_clear: got %0d want 0", v); end
    endtask

    task automatic test_random();
        int dv;
        int L;
        int sel;
        for (int it = 0; it < 3; it++) begin
            dv = $urandom_range(0, 2);
            L = (dv + 1) * PER;
            for (int c = 0; c < W; c++) begin
                sel = $urandom_range(0, 5);
                if (sel == 0) duty_m[c] = '0;
                else if (sel == 1) duty_m[c] = 11'd1024;
                else if (sel == 2) duty_m[c] = 11'($urandom_range(1025, 2047));
                else duty_m[c] = 11'($urandom_range(1, 1023));
            end
            run_check("random", dv, 2, $urandom_range(0, 2 * L - 10),
                      $urandom_range(0, W - 1), 11'($urandom_range(0, 2047)));
        end
    endtask

`ifdef PWM_POLARITY_EN
    task automatic test_polarity();
        for (int c = 0; c < W; c++) duty_m[c] = '0;
        duty_m[0] = 11'd256;
        pol_m = 8'h01;
        wr(ADDR_CTRL, 32'd0);
        wr(ADDR_POL, 32'h01);
        n_tests++;
        if (pwm[0] !== 1'b1) begin n_fail++; $display("FAIL pol_idle: got %0b want 1", pwm[0]); end
        run_check("polarity", 0, 1, -1, 0, '0);
        pol_m = '0;
        wr(ADDR_POL, 32'd0);
    endtask
`endif

    initial begin
        reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
        pol_m = '0;
        for (int c = 0; c < W; c++) duty_m[c] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        test_reset();
        test_regs();
        test_basic();
        test_extremes();
        test_mid_write();
        test_disable();
`ifdef PWM_POLARITY_EN
        test_polarity();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_dbuf_core.md
Name: pwm_dbuf_core

Overview:
- Multi-channel PWM core for one MMIO slot of the vanilla MMIO subsystem; its output drives the board `pwm[7:0]` bus that feeds the `ja` header pins.
- The MCS-bridge slot bus writes the prescaler, control, and per-channel duty registers.
- Duty writes are double-buffered: a new duty takes effect only at a PWM period boundary, so outputs never glitch mid-period.

Parameters:
- W, 8: number of PWM channels (1..16).
- R, 10: duty/counter resolution in bits; period = 2^R ticks.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cs  in  1  slot chip select.
- read  in  1  read strobe (qualified by cs).
- write  in  1  write strobe (qualified by cs).
- addr  in  5  slot register address.
- wr_data  in  32  write data.
- rd_data  out  32  read data; combinational mux of registers.
- pwm  out  W  registered PWM outputs.

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high. On reset every register clears to 0, so `pwm` = 0 and `rd_data` = 0 (unmapped/zero regs).
- Register map (word address):
  - 0 DVSR [31:0] R/W.
  - 1 CTRL R/W; bit0 = en, other bits read 0.
  - 2 PCNT R/clear: 32-bit completed-period count; any write clears it to 0.
  - 3 POL: see optional feature.
  - 0x10+i: DUTY_i shadow [R:0], R/W, for i < W.
  - All other addresses read 0; writes to them are ignored.
- Write decode: a write takes effect when cs && write; the register updates at that clock edge.
- Prescaler:
  - q counts 0..DVSR; tick = (q == DVSR), then q wraps to 0.
  - DVSR = 0 gives a tick every cycle.
  - DVSR written lower than the current q: q keeps counting up, wraps at 2^32, then counts normally. No forced reload.
- Counter:
  - d (R bits) increments on tick and wraps 2^R-1 -> 0.
  - Boundary = tick && d == 2^R-1.
- Double buffer:
  - On boundary: active_i <= shadow_i for all channels, and PCNT increments (wraps at 2^32).
  - Write to DUTY_i in the same cycle as a boundary: active_i loads the old shadow value; the new value applies at the next boundary.
- Disabled (en = 0):
  - q and d are held at 0.
  - active_i <= shadow_i every cycle.
  - pwm = 0; PCNT is held.
- Enable 0 -> 1: counting starts from q = d = 0 with the current shadow values.
- Disable mid-period: on the next edge pwm is 0 and the counters are at 0. No completion of the period.
- Output: pwm_i <= en && (d < active_i), registered, one cycle after the d value.
  - Duty 0: constant low.
  - Duty >= 2^R: constant high (the duty is R+1 bits, so 2^R is representable).

Optional Feature:
- Macro: PWM_POLARITY_EN.
- Defined:
  - Addr 3 is POL [W-1:0], R/W, reset 0.
  - pwm_i = computed_i XOR POL_i when en = 1.
  - When en = 0, pwm_i = POL_i, i.e. the idle level.
  - POL changes apply on the next edge; they are not double-buffered.
- Not defined: addr 3 reads 0, writes are ignored, and no inversion is applied.

Decomposition:
- Package pwm_dbuf_pkg holds:
  - localparams for the register addresses (ADDR_DVSR = 0, ADDR_CTRL = 1, ADDR_PCNT = 2, ADDR_POL = 3, ADDR_DUTY_BASE = 5'h10);
  - CTRL bit index EN_BIT = 0.
- One sub-module, pwm_timebase: prescaler + R-bit counter, with outputs d, tick, and boundary, and an input en.
- Channel compare logic, register file, and read mux stay in the top module.

Test Plan:
- Reset, then read addrs 0, 1, 2, 0x10 -> all 0; pwm = 0 for 20 cycles.
- DVSR = 0, DUTY_0 = 512, en = 1 -> pwm[0] high exactly 512 cycles, low 512 cycles, repeating. PCNT = 3 after 3×1024 cycles.
- DVSR = 1, DUTY_1 = 0, DUTY_2 = 1024 -> pwm[1] constant 0; pwm[2] constant 1. Period = 2048 clocks.
- DUTY_0 = 100 running; write DUTY_0 = 700 mid-period -> the current period keeps 100 high cycles, the next period has 700.
  - Repeat with the write landing on the boundary cycle -> one more period at 100, then 700.
- en 1 -> 0 at d = 300 -> pwm = 0 next cycle. Re-enable -> the high phase restarts at d = 0 with the full duty.
  - Write to PCNT -> reads 0.
- With PWM_POLARITY_EN: POL = 0x01, en = 0 -> pwm[0] = 1; en = 1, DUTY_0 = 256 -> pwm[0] low 256 cycles, high 768.
  - Without the macro: addr 3 reads 0 after a write of 0xFF.
